sdio_irq_bank: RTL and testbench

Parametrised interrupt/status register bank for the SDIO controller, running entirely in the `sys_clk` domain. It latches per-source events into write-1-to-clear status bits and gates them with enables, supporting both edge and level sources and a software force path. It drives a registered, hold-off-throttled interrupt line. It sits beside the controller's byte-wide register file on the same `reg_addr` bus, generalising the fixed 8-bit irq/err status bytes to any bus width and source count.

---
 rtl/sdio_irq_bank.sv | 165 ++++++++++++++++
 tb/tb_sdio_irq_bank.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_irq_bank.sv
// Interrupt/status register bank for the SDIO controller: W1C status with enables,
// edge/level source selection, software force and a hold-off throttled irq line.
module sdio_irq_bank #(
    parameter int         DW      = 8,
    parameter int         NUM_IRQ = 12,
    parameter logic [7:0] BASE    = 8'd64,
    parameter int         HOLDOFF = 0
) (
    input  logic               sys_clk,
    input  logic               rstn,
    input  logic               reg_wr,
    input  logic               reg_rd,
    input  logic [7:0]         reg_addr,
    input  logic [DW-1:0]      reg_wdata,
    output logic [DW-1:0]      reg_rdata,
    output logic               reg_rvalid,
    input  logic [NUM_IRQ-1:0] irq_src,
    output logic               irq,
    output logic [NUM_IRQ-1:0] irq_status
);

    localparam int         NW        = (NUM_IRQ + DW - 1) / DW;
    localparam int         PW        = NW * DW;
    localparam logic [7:0] HOLDOFF_L = 8'(HOLDOFF);

    localparam logic [2:0] SEL_STATUS = 3'd0;
    localparam logic [2:0] SEL_ENABLE = 3'd1;
    localparam logic [2:0] SEL_FORCE  = 3'd2;
    localparam logic [2:0] SEL_RAW    = 3'd3;
    localparam logic [2:0] SEL_EDGE   = 3'd4;

    logic [NUM_IRQ-1:0] status_q, status_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] edge_sel_q, edge_sel_d;
    logic [NUM_IRQ-1:0] src_d1_q, src_d1_d;
    logic [7:0]         holdoff_q, holdoff_d;
    logic               irq_q, irq_d;
    logic [DW-1:0]      reg_rdata_q, reg_rdata_d;
    logic               reg_rvalid_q, reg_rvalid_d;

    logic [8:0]         off;
    logic [2:0]         sel;
    logic [1:0]         word;
    logic               in_range;
    logic               wr_status, wr_enable, wr_force, wr_edge;
    logic [NUM_IRQ-1:0] word_mask;
    logic [NUM_IRQ-1:0] wr_bits;
    logic [NUM_IRQ-1:0] clr_bits;
    logic [NUM_IRQ-1:0] force_bits;
    logic [NUM_IRQ-1:0] event_bits;
    logic [NUM_IRQ-1:0] set_bits;
    logic [NUM_IRQ-1:0] cleared_bits;
    logic [NUM_IRQ-1:0] rd_bits;
    logic [PW-1:0]      rd_full;
    logic [DW-1:0]      rd_word;

    // Offset is computed in 9 bits so addresses below BASE land far out of range.
    assign off      = {1'b0, reg_addr} - {1'b0, BASE};
    assign sel      = off[4:2];
    assign word     = off[1:0];
    assign in_range = (off < 9'd20) && (int'(word) < NW);

    assign wr_status = reg_wr && in_range && (sel == SEL_STATUS);
    assign wr_enable = reg_wr && in_range && (sel == SEL_ENABLE);
    assign wr_force  = reg_wr && in_range && (sel == SEL_FORCE);
    assign wr_edge   = reg_wr && in_range && (sel == SEL_EDGE);

    always_comb begin
        word_mask = '0;
        wr_bits   = '0;
        for (int n = 0; n < NUM_IRQ; n++) begin
            word_mask[n] = (int'(word) == (n / DW));
            wr_bits[n]   = reg_wdata[n % DW] & word_mask[n];
        end
    end

    always_comb begin
        clr_bits   = wr_status ? wr_bits : '0;
        force_bits = wr_force ? wr_bits : '0;
        event_bits = irq_src & (~edge_sel_q | ~src_d1_q);
        set_bits   = event_bits | force_bits;
        status_d   = (status_q & ~clr_bits) | set_bits;
        src_d1_d   = irq_src;

        enable_d   = enable_q;
        edge_sel_d = edge_sel_q;
        if (wr_enable) begin
            enable_d = (enable_q & ~word_mask) | wr_bits;
        end
        if (wr_edge) begin
            edge_sel_d = (edge_sel_q & ~word_mask) | wr_bits;
        end
    end

    // Hold-off restarts only when a write really drops a pending bit; a bit
    // re-set by its source in the same cycle was never cleared.
    always_comb begin
        cleared_bits = status_q & clr_bits & ~set_bits;
        if (wr_status && (|cleared_bits)) begin
            holdoff_d = HOLDOFF_L;
        end else if (holdoff_q != 8'd0) begin
            holdoff_d = holdoff_q - 8'd1;
        end else begin
            holdoff_d = 8'd0;
        end
        irq_d = (|(status_q & enable_q)) && (holdoff_q == 8'd0);
    end

    always_comb begin
        rd_bits = '0;
        case (sel)
            SEL_STATUS: rd_bits = status_q;
            SEL_ENABLE: rd_bits = enable_q;
            SEL_FORCE:  rd_bits = '0;
            SEL_RAW:    rd_bits = src_d1_q;
            SEL_EDGE:   rd_bits = edge_sel_q;
            default:    rd_bits = '0;
        endcase
        rd_full                = '0;
        rd_full[NUM_IRQ-1:0]   = rd_bits;
        rd_word                = '0;
        for (int i = 0; i < NW; i++) begin
            if (int'(word) == i) begin
                rd_word = rd_full[i*DW +: DW];
            end
        end
    end

    // Reads sample pre-write state, so a read paired with a write sees old data.
    always_comb begin
        reg_rdata_d  = reg_rdata_q;
        reg_rvalid_d = reg_rd;
        if (reg_rd) begin
            reg_rdata_d = in_range ? rd_word : '0;
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            status_q     <= '0;
            enable_q     <= '0;
            edge_sel_q   <= '0;
            src_d1_q     <= '0;
            holdoff_q    <= 8'd0;
            irq_q        <= 1'b0;
            reg_rdata_q  <= '0;
            reg_rvalid_q <= 1'b0;
        end else begin
            status_q     <= status_d;
            enable_q     <= enable_d;
            edge_sel_q   <= edge_sel_d;
            src_d1_q     <= src_d1_d;
            holdoff_q    <= holdoff_d;
            irq_q        <= irq_d;
            reg_rdata_q  <= reg_rdata_d;
            reg_rvalid_q <= reg_rvalid_d;
        end
    end

    assign reg_rdata  = reg_rdata_q;
    assign reg_rvalid = reg_rvalid_q;
    assign irq        = irq_q;
    assign irq_status = status_q;

endmodule

// File: tb/tb_sdio_irq_bank.sv
// Directed bench for sdio_irq_bank (DW=8, NUM_IRQ=12, BASE=64, HOLDOFF=4):
// a register-access vector table plus hand-written interrupt sequences.
module tb_sdio_irq_bank;

    logic        sys_clk;
    logic        rstn;
    logic        reg_wr;
    logic        reg_rd;
    logic [7:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        reg_rvalid;
    logic [11:0] irq_src;
    logic        irq;
    logic [11:0] irq_status;

    int checks;
    int errors;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    sdio_irq_bank #(
        .DW(8), .NUM_IRQ(12), .BASE(8'd64), .HOLDOFF(4)
    ) dut (
        .sys_clk(sys_clk),
        .rstn(rstn),
        .reg_wr(reg_wr),
        .reg_rd(reg_rd),
        .reg_addr(reg_addr),
        .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata),
        .reg_rvalid(reg_rvalid),
        .irq_src(irq_src),
        .irq(irq),
        .irq_status(irq_status)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [7:0] data);
        reg_wr    = 1'b1;
        reg_addr  = addr;
        reg_wdata = data;
        tick();
        reg_wr    = 1'b0;
    endtask

    task automatic rd_reg(input logic [7:0] addr, input logic [7:0] exp, input string name);
        reg_rd   = 1'b1;
        reg_addr = addr;
        tick();
        reg_rd   = 1'b0;
        check_output({name, " rvalid"}, 32'(reg_rvalid), 32'd1);
        check_output({name, " rdata"}, 32'(reg_rdata), 32'(exp));
    endtask

    task automatic apply_stimulus(input int idx, input vec_t v);
        reg_wr    = v.wr;
        reg_rd    = v.rd;
        reg_addr  = v.addr;
        reg_wdata = v.wdata;
        tick();
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
        check_output($sformatf("vec%0d rvalid", idx), 32'(reg_rvalid), 32'(v.rd));
        if (v.rd) begin
            check_output($sformatf("vec%0d rdata", idx), 32'(reg_rdata), 32'(v.exp_rdata));
        end
        check_output($sformatf("vec%0d irq", idx), 32'(irq), 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rstn      = 1'b0;
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
        reg_addr  = 8'd0;
        reg_wdata = 8'd0;
        irq_src   = 12'd0;

        //             wr    rd    addr   wdata  exp
        vecs.push_back('{1'b1, 1'b0, 8'd68, 8'hA5, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 8'd68, 8'h00, 8'hA5});
        vecs.push_back('{1'b1, 1'b0, 8'd69, 8'hFF, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 8'd69, 8'h00, 8'h0F});
        vecs.push_back('{1'b1, 1'b0, 8'd65, 8'hFF, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 8'd65, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 1'b0, 8'd80, 8'h3C, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 8'd80, 8'h00, 8'h3C});
        vecs.push_back('{1'b1, 1'b0, 8'd81, 8'hF1, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 8'd81, 8'h00, 8'h01});
        vecs.push_back('{1'b1, 1'b0, 8'd72, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 8'd72, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 8'd76, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 1'b0, 8'd84, 8'hFF, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 8'd84, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 8'd67, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 1'b0, 8'd71, 8'hFF, 8'h00});
        vecs.push_back('{1'b1, 1'b1, 8'd68, 8'h11, 8'hA5});
        vecs.push_back('{1'b0, 1'b1, 8'd68, 8'h00, 8'h11});
        vecs.push_back('{1'b0, 1'b1, 8'd69, 8'h00, 8'h0F});
        vecs.push_back('{1'b1, 1'b0, 8'd68, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 1'b0, 8'd69, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 1'b0, 8'd80, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 1'b0, 8'd81, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 8'd80, 8'h00, 8'h00});

        // Reset state
        repeat (2) @(posedge sys_clk);
        #1;
        check_output("reset irq", 32'(irq), 32'd0);
        check_output("reset rvalid", 32'(reg_rvalid), 32'd0);
        check_output("reset rdata", 32'(reg_rdata), 32'd0);
        check_output("reset status", 32'(irq_status), 32'd0);
        rstn = 1'b1;
        tick();

        for (int a = 64; a <= 81; a++) begin
            rd_reg(8'(a), 8'h00, $sformatf("init read %0d", a));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(i, vecs[i]);
        end

        // Rising-edge source on bit 9
        wr_reg(8'd81, 8'h02);
        wr_reg(8'd69, 8'h02);
        irq_src[9] = 1'b1;
        tick();
        check_output("edge status set", 32'(irq_status), 32'h200);
        check_output("edge irq not yet", 32'(irq), 32'd0);
        tick();
        check_output("edge irq rise", 32'(irq), 32'd1);
        rd_reg(8'd77, 8'h02, "raw word1");
        tick();
        tick();
        irq_src[9] = 1'b0;
        rd_reg(8'd65, 8'h02, "edge status word1");
        wr_reg(8'd65, 8'h02);
        check_output("edge w1c status", 32'(irq_status), 32'h000);
        check_output("edge irq at clear", 32'(irq), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output($sformatf("edge irq low %0d", i), 32'(irq), 32'd0);
        end
        wr_reg(8'd81, 8'h00);
        wr_reg(8'd69, 8'h00);
        repeat (8) tick();

        // Level source on bit 0 with a colliding W1C
        wr_reg(8'd68, 8'h01);
        irq_src[0] = 1'b1;
        tick();
        check_output("level status set", 32'(irq_status), 32'h001);
        tick();
        check_output("level irq rise", 32'(irq), 32'd1);
        wr_reg(8'd64, 8'h01);
        check_output("set beats clear", 32'(irq_status), 32'h001);
        check_output("level irq held", 32'(irq), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output($sformatf("level irq stays %0d", i), 32'(irq), 32'd1);
        end
        irq_src[0] = 1'b0;
        tick();
        check_output("level status latched", 32'(irq_status), 32'h001);
        wr_reg(8'd64, 8'h01);
        check_output("level cleared", 32'(irq_status), 32'h000);
        wr_reg(8'd68, 8'h00);
        repeat (8) tick();

        // Hold-off after clearing bit 3
        wr_reg(8'd68, 8'h08);
        irq_src[3] = 1'b1;
        tick();
        irq_src[3] = 1'b0;
        check_output("holdoff status set", 32'(irq_status), 32'h008);
        tick();
        check_output("holdoff irq rise", 32'(irq), 32'd1);
        wr_reg(8'd64, 8'h08);
        check_output("holdoff cleared", 32'(irq_status), 32'h000);
        irq_src[3] = 1'b1;
        tick();
        irq_src[3] = 1'b0;
        check_output("holdoff status reset", 32'(irq_status), 32'h008);
        check_output("holdoff irq k+1", 32'(irq), 32'd0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check_output($sformatf("holdoff irq k+%0d", i), 32'(irq), 32'd0);
        end
        tick();
        check_output("holdoff irq k+5", 32'(irq), 32'd1);
        wr_reg(8'd64, 8'h08);
        wr_reg(8'd68, 8'h00);
        repeat (8) tick();

        // Force path and read-with-W1C
        wr_reg(8'd68, 8'h80);
        wr_reg(8'd72, 8'h80);
        check_output("force status", 32'(irq_status), 32'h080);
        check_output("force irq not yet", 32'(irq), 32'd0);
        tick();
        check_output("force irq rise", 32'(irq), 32'd1);
        rd_reg(8'd72, 8'h00, "force reads zero");
        reg_rd    = 1'b1;
        reg_wr    = 1'b1;
        reg_addr  = 8'd64;
        reg_wdata = 8'h80;
        tick();
        reg_rd    = 1'b0;
        reg_wr    = 1'b0;
        check_output("rd+w1c rvalid", 32'(reg_rvalid), 32'd1);
        check_output("rd+w1c old data", 32'(reg_rdata), 32'h80);
        check_output("rd+w1c status", 32'(irq_status), 32'h000);
        rd_reg(8'd64, 8'h00, "after w1c read");
        check_output("after w1c irq", 32'(irq), 32'd0);
        repeat (6) tick();

        // Reset in the middle of activity
        wr_reg(8'd72, 8'h80);
        tick();
        check_output("pre-reset irq", 32'(irq), 32'd1);
        reg_rd   = 1'b1;
        reg_addr = 8'd64;
        tick();
        check_output("pre-reset rvalid", 32'(reg_rvalid), 32'd1);
        check_output("pre-reset rdata", 32'(reg_rdata), 32'h80);
        #2;
        rstn = 1'b0;
        #1;
        check_output("async reset irq", 32'(irq), 32'd0);
        check_output("async reset rvalid", 32'(reg_rvalid), 32'd0);
        check_output("async reset rdata", 32'(reg_rdata), 32'd0);
        check_output("async reset status", 32'(irq_status), 32'd0);
        tick();
        check_output("reset hold rvalid", 32'(reg_rvalid), 32'd0);
        reg_rd = 1'b0;
        #2;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output($sformatf("post-reset rvalid %0d", i), 32'(reg_rvalid), 32'd0);
        end
        rd_reg(8'd68, 8'h00, "post-reset enable");
        check_output("post-reset irq", 32'(irq), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
